// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Resolves conditional branches (beq, bne, bgez/bltz, bgtz, blez) in the ID
//   stage. Fetch/decode are held while the branch waits for forwarded operands.
//   A taken branch produces a one-cycle PC redirect together with an IF flush.
//   Saturating statistics counters track resolved and taken branches.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            ID stage holds a valid instruction
//   id_opcode/rt/imm    instruction fields [31:26], [20:16], [15:0]
//   id_pc_plus4         PC+4 of the ID instruction
//   id_rs_val/rt_val    forwarded register operands
//   operands_ready      forwarded operands are final this cycle
//   pipe_flush          higher-priority flush; aborts any resolution
//   stall_if_id         hold PC and the IF/ID register
//   redirect_valid      load PC from redirect_pc this cycle
//   redirect_pc         registered branch target
//   flush_if            squash the IF/ID instruction on the next edge
//   branch_cnt          resolved branches (saturating)
//   taken_cnt           taken branches (saturating)
//
// Handshake: the branch is accepted in IDLE in the same cycle stall_if_id goes
// high; the instruction must stay in ID (held by the stall) until the RESOLVE
// cycle, where stall_if_id drops so the branch advances exactly once.

module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rt,
    input  logic [15:0]      id_imm,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic             operands_ready,
    input  logic             pipe_flush,
    output logic             stall_if_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  opcode_q;
    logic        regimm_ge_q;   // id_rt[0]: 1 = bgez, 0 = bltz
    logic [15:0] imm_q;
    logic [31:0] pc4_q;
    logic        taken_q;
    logic [31:0] target_q;

    logic        is_branch;
    logic        detect;
    logic        cond;
    logic        rs_neg;
    logic        rs_zero;
    logic        unused_rt_bits;

    // Only id_rt[0] distinguishes bgez/bltz; link variants are not handled.
    assign unused_rt_bits = ^id_rt[4:1];

    assign is_branch = (id_opcode == OP_BEQ)  || (id_opcode == OP_BNE)  ||
                       (id_opcode == OP_REGIMM) || (id_opcode == OP_BGTZ) ||
                       (id_opcode == OP_BLEZ);
    assign detect    = id_valid && is_branch && !pipe_flush;

    assign rs_neg  = id_rs_val[31];
    assign rs_zero = (id_rs_val == 32'd0);

    // Condition uses the live forwarded operands; only the opcode is latched.
    always_comb begin
        cond = 1'b0;
        case (opcode_q)
            OP_BEQ:    cond = (id_rs_val == id_rt_val);
            OP_BNE:    cond = (id_rs_val != id_rt_val);
            OP_REGIMM: cond = regimm_ge_q ? !rs_neg : rs_neg;
            OP_BGTZ:   cond = !rs_neg && !rs_zero;
            OP_BLEZ:   cond = rs_neg || rs_zero;
            default:   cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opcode_q    <= 6'd0;
            regimm_ge_q <= 1'b0;
            imm_q       <= 16'd0;
            pc4_q       <= 32'd0;
            taken_q     <= 1'b0;
            target_q    <= 32'd0;
            branch_cnt  <= '0;
            taken_cnt   <= '0;
        end else if (pipe_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (detect) begin
                        opcode_q    <= id_opcode;
                        regimm_ge_q <= id_rt[0];
                        imm_q       <= id_imm;
                        pc4_q       <= id_pc_plus4;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (operands_ready) begin
                        taken_q  <= cond;
                        target_q <= pc4_q + {{14{imm_q[15]}}, imm_q, 2'b00};
                        state    <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (branch_cnt != CNT_MAX) begin
                        branch_cnt <= branch_cnt + CNT_ONE;
                    end
                    if (taken_q && (taken_cnt != CNT_MAX)) begin
                        taken_cnt <= taken_cnt + CNT_ONE;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall_if_id    = ((state == S_IDLE) && detect) || (state == S_WAIT);
    assign redirect_valid = (state == S_RESOLVE) && taken_q && !pipe_flush;
    assign flush_if       = redirect_valid;
    assign redirect_pc    = target_q;

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences conditional-branch resolution in the ID stage of the pipelined MIPS core.
- Detects branch opcodes (beq, bne, REGIMM bgez/bltz, bgtz, blez) and stalls fetch/decode until forwarded operands are ready.
- Evaluates the condition and issues a one-cycle PC redirect plus IF flush when the branch is taken.
- Keeps saturating branch and taken-branch statistics counters for the debug register file.

Parameters:
- CNT_W, 16: width of the branch_cnt and taken_cnt statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_opcode  in  6  instr[31:26]
- id_rt  in  5  instr[20:16]; selects the REGIMM variant
- id_imm  in  16  instr[15:0]
- id_pc_plus4  in  32  PC+4 of the ID instruction
- id_rs_val  in  32  forwarded rs value
- id_rt_val  in  32  forwarded rt value
- operands_ready  in  1  forwarding unit: rs/rt values are final this cycle
- pipe_flush  in  1  higher-priority flush (exception/eret); aborts resolution
- stall_if_id  out  1  hold PC and IF/ID register
- redirect_valid  out  1  load PC from redirect_pc this cycle
- redirect_pc  out  32  branch target
- flush_if  out  1  squash the instruction in IF/ID on the next edge
- branch_cnt  out  CNT_W  resolved branches, saturating
- taken_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. Reset forces state IDLE; taken_q, target_q, branch_cnt and taken_cnt go to 0; all outputs are 0.
- is_branch = opcode in {0x04, 0x05, 0x01, 0x07, 0x06}.
- FSM states:
  - IDLE: if id_valid & is_branch & ~pipe_flush, latch opcode, rt, imm and pc_plus4, then go to WAIT.
  - WAIT: stay while ~operands_ready. When operands_ready, evaluate the condition on the current id_rs_val/id_rt_val, register taken_q and target_q, then go to RESOLVE.
  - RESOLVE: lasts exactly one cycle, then goes to IDLE. id_valid is ignored in this cycle because the branch itself is still in ID.
- pipe_flush in any state: next state is IDLE, no redirect, no counter update. pipe_flush has priority over every transition.
- stall_if_id is combinational: (state==IDLE & id_valid & is_branch & ~pipe_flush) | (state==WAIT). It is 0 in RESOLVE so the branch advances exactly once.
- redirect_valid and flush_if are combinational: (state==RESOLVE) & taken_q & ~pipe_flush.
- redirect_pc = target_q at all times; 0 after reset.
- Branch conditions (signed compares on 32 bits):
  - beq: rs==rt
  - bne: rs!=rt
  - 0x01 with rt[0]=1 (bgez): rs>=0
  - 0x01 with rt[0]=0 (bltz): rs<0
  - bgtz: rs>0
  - blez: rs<=0
  - The other rt bits of REGIMM are ignored; link variants are out of scope.
- Target = pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), modulo 2^32; wrap-around is allowed.
- Latency: detect at cycle N, WAIT at N+1. With operands_ready at N+1, RESOLVE and redirect occur at N+2 (minimum penalty 2 stall cycles). Each extra not-ready cycle adds one cycle.
- Counters: in RESOLVE & ~pipe_flush, branch_cnt increments and taken_cnt increments if taken_q. Both saturate at 2^CNT_W-1.
- Back-to-back branches: a branch arriving in ID the cycle after RESOLVE is detected normally from IDLE.
- Reset asserted mid-resolution: immediate IDLE; the pending redirect is dropped.

Test Plan:
- Taken beq: rs=rt=0x5, imm=0x0003, pc_plus4=0x0040_0004, operands_ready=1 → stall_if_id high 2 cycles; RESOLVE cycle redirect_valid=flush_if=1, redirect_pc=0x0040_0010; branch_cnt=1, taken_cnt=1.
- Not-taken bne with operands_ready low for 3 cycles: rs=rt=0x7 → stall_if_id high 5 cycles total, redirect_valid never asserted; branch_cnt increments, taken_cnt unchanged.
- Signed REGIMM/bgtz/blez edges: bltz rs=0x8000_0000 taken; bgez rs=0 taken; bgtz rs=0 not taken; blez rs=0 taken; bltz with id_rt=0x10 and rs=0xFFFF_FFFF taken.
- Negative offset and wrap: imm=0xFFFF, pc_plus4=0x0000_0000 → redirect_pc=0xFFFF_FFFC.
- pipe_flush during WAIT, then separately during RESOLVE → return to IDLE, redirect_valid=0, counters unchanged; non-branch opcode 0x08 never stalls.
- CNT_W=2 saturation: 5 taken branches → branch_cnt=taken_cnt=3; rst_n low asynchronously in WAIT → outputs and counters 0 before the next edge.
